// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the byte-serial memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        Size1B = 2'd0,
        Size2B = 2'd1,
        Size4B = 2'd2,
        Size8B = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrStrobe,
        StDone
    } state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    function automatic logic [3:0] bytes_of(size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_byte_shifter.sv
// Big-endian byte serialiser for stores and byte assembler for loads, sharing one register.
module mem_byte_shifter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [63:0] load_data_i,
    input  size_e       size_i,
    input  logic        shift_i,
    input  logic [7:0]  shift_byte_i,
    output logic [7:0]  load_byte_o,
    output logic [7:0]  byte_o,
    output logic [63:0] next_result_o
);

    logic [63:0] data_q;
    logic [63:0] aligned;

    // Left-align the used bytes so the most significant one leaves first.
    always_comb begin
        case (size_i)
            Size1B:  aligned = {load_data_i[7:0], 56'd0};
            Size2B:  aligned = {load_data_i[15:0], 48'd0};
            Size4B:  aligned = {load_data_i[31:0], 32'd0};
            default: aligned = load_data_i;
        endcase
    end

    assign load_byte_o   = aligned[63:56];
    assign byte_o        = data_q[63:56];
    assign next_result_o = {data_q[55:0], shift_byte_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= aligned;
        end else if (shift_i) begin
            data_q <= next_result_o;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide ram between instruction fetch and data memory, one byte beat per access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned       MADDR_SZ = 32,
    parameter longint unsigned   MEM_SZ   = 64'd1 << 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [MADDR_SZ-1:0] if_addr,
    output logic [31:0]         if_rdata,
    output logic                if_done,
    output logic                if_err,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [1:0]          dm_size,
    input  logic [MADDR_SZ-1:0] dm_addr,
    input  logic [63:0]         dm_wdata,
    output logic [63:0]         dm_rdata,
    output logic                dm_done,
    output logic                dm_err,
    output logic [MADDR_SZ-1:0] ram_raddr,
    input  logic [7:0]          ram_rdata,
    output logic                ram_re,
    output logic [MADDR_SZ-1:0] ram_waddr,
    output logic [7:0]          ram_wdata,
    output logic                ram_we,
    output logic                busy
);

    state_e  state_q;
    logic    port_q;
    logic    last_dm_q;
    size_e   size_q;
    logic [2:0] beat_q;

    logic                grant_dm;
    logic                any_req;
    size_e               g_size;
    logic [MADDR_SZ-1:0] g_addr;
    logic                g_we;
    logic [3:0]          g_n;
    logic                g_err;
    logic                load_en;
    logic                shift_en;
    logic                last_beat;
    logic [7:0]          load_byte;
    logic [7:0]          cur_byte;
    logic [63:0]         next_result;

    // DM wins a tie unless it took the previous grant.
    assign grant_dm = dm_req && (!if_req || !last_dm_q);
    assign any_req  = if_req || dm_req;
    assign g_size   = grant_dm ? size_e'(dm_size) : Size4B;
    assign g_addr   = grant_dm ? dm_addr : if_addr;
    assign g_we     = grant_dm && dm_we;
    assign g_n      = bytes_of(g_size);
    assign g_err    = ((g_addr & (MADDR_SZ'(g_n) - MADDR_SZ'(1))) != '0) ||
                      ((64'(g_addr) + 64'(g_n) - 64'd1) >= MEM_SZ);

    assign load_en   = (state_q == StIdle) && any_req && !g_err;
    assign shift_en  = (state_q == StRd) || (state_q == StWrSetup);
    assign last_beat = (beat_q == 3'(bytes_of(size_q) - 4'd1));

    mem_byte_shifter u_shifter (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load_en),
        .load_data_i   (g_we ? dm_wdata : 64'd0),
        .size_i        (g_size),
        .shift_i       (shift_en),
        .shift_byte_i  (ram_rdata),
        .load_byte_o   (load_byte),
        .byte_o        (cur_byte),
        .next_result_o (next_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            port_q    <= PORT_IF;
            last_dm_q <= 1'b0;
            size_q    <= Size1B;
            beat_q    <= '0;
            if_rdata  <= '0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            dm_rdata  <= '0;
            dm_done   <= 1'b0;
            dm_err    <= 1'b0;
            ram_raddr <= '0;
            ram_re    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        port_q    <= grant_dm;
                        last_dm_q <= grant_dm;
                        size_q    <= g_size;
                        beat_q    <= '0;
                        busy      <= 1'b1;
                        if (g_err) begin
                            state_q <= StDone;
                            if (grant_dm) begin
                                dm_done <= 1'b1;
                                dm_err  <= 1'b1;
                            end else begin
                                if_done <= 1'b1;
                                if_err  <= 1'b1;
                            end
                        end else if (g_we) begin
                            state_q   <= StWrSetup;
                            ram_waddr <= g_addr;
                            ram_wdata <= load_byte;
                        end else begin
                            state_q   <= StRd;
                            ram_raddr <= g_addr;
                            ram_re    <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    if (last_beat) begin
                        state_q <= StDone;
                        ram_re  <= 1'b0;
                        if (port_q == PORT_DM) begin
                            dm_rdata <= next_result;
                            dm_done  <= 1'b1;
                        end else begin
                            if_rdata <= next_result[31:0];
                            if_done  <= 1'b1;
                        end
                    end else begin
                        beat_q    <= beat_q + 3'd1;
                        ram_raddr <= ram_raddr + MADDR_SZ'(1);
                    end
                end
                StWrSetup: begin
                    state_q <= StWrStrobe;
                    ram_we  <= 1'b1;
                end
                StWrStrobe: begin
                    ram_we <= 1'b0;
                    if (last_beat) begin
                        state_q <= StDone;
                        dm_done <= 1'b1;
                    end else begin
                        // The shifter advanced during setup, so cur_byte is already the next byte.
                        state_q   <= StWrSetup;
                        beat_q    <= beat_q + 3'd1;
                        ram_waddr <= ram_waddr + MADDR_SZ'(1);
                        ram_wdata <= cur_byte;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    if_done <= 1'b0;
                    if_err  <= 1'b0;
                    dm_done <= 1'b0;
                    dm_err  <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits between the CPU pipeline and the byte-wide ram.
- Shares the ram between two requesters:
  - instruction fetch (IF): 32-bit read only.
  - data memory (DM): 1/2/4/8-byte load/store.
- Serialises every access into big-endian byte beats on the ram's separate read/write address ports.
- Generates the edge-triggered write strobe, assembles read bytes into words, and reports done or error to the requester.

Parameters:
MADDR_SZ, 32, address width of requester and ram ports
MEM_SZ, 2**25, ram size in bytes; any byte address >= MEM_SZ is an error

Ports:
clk  in  1  clock
rst  in  1  reset (decided: asynchronous, active-high)
if_req  in  1  fetch request, held until if_done
if_addr  in  MADDR_SZ  fetch byte address
if_rdata  out  32  fetched instruction, big-endian
if_done  out  1  one-cycle completion pulse
if_err  out  1  misaligned/out-of-range, valid with if_done
dm_req  in  1  data request, held until dm_done
dm_we  in  1  1=store, 0=load
dm_size  in  2  0=1B, 1=2B, 2=4B, 3=8B
dm_addr  in  MADDR_SZ  data byte address
dm_wdata  in  64  store data; low N bytes used
dm_rdata  out  64  load data, zero-extended into low N bytes
dm_done  out  1  one-cycle completion pulse
dm_err  out  1  error, valid with dm_done
ram_raddr  out  MADDR_SZ  ram read address
ram_rdata  in  8  ram combinational read data
ram_re  out  1  high while read beats are in progress
ram_waddr  out  MADDR_SZ  ram write address
ram_wdata  out  8  ram write byte
ram_we  out  1  write strobe; ram writes on its rising edge
busy  out  1  FSM not in IDLE

Behaviour:
- All outputs are registered. On reset, every output is 0 and the FSM goes to IDLE.
- Cycle numbering: cycle 0 is the IDLE cycle in which the request is sampled; the grant takes effect at the end of cycle 0.
- States: IDLE, RD, WR_SETUP, WR_STROBE, DONE.
- IDLE arbitration:
  - Only one request pending: grant it.
  - Both pending: DM wins, except when the previous grant was DM, in which case IF wins.
- Grant:
  - Latch port, address, size (IF size = 4B), we and wdata. Requester inputs are ignored after the grant.
  - N = 1 << size.
- Error check at grant:
  - Error if addr is not a multiple of N, or addr+N-1 >= MEM_SZ.
  - On error, go straight to DONE: the done and err pulses appear in cycle 1, rdata is unchanged, and the ram is not accessed.
- Load/fetch:
  - At grant: ram_raddr = addr, ram_re = 1, beat counter = 0.
  - Each RD cycle: shift ram_rdata into the assembly register (first byte is most significant); on every beat except the last, ram_raddr increments.
  - After N RD cycles (cycles 1..N), go to DONE. ram_re drops on entry to DONE.
  - Rdata is updated at DONE entry and held until that port's next successful transaction.
  - Done pulse in cycle N+1.
- Store, per byte i:
  - WR_SETUP: ram_waddr = addr+i, ram_wdata = byte i (big-endian: byte 0 is the most significant used byte), ram_we = 0.
  - WR_STROBE: same address and data, ram_we = 1.
  - Done pulse in cycle 2N+1. ram_we is low in DONE.
- DONE: assert the granted port's done (and err, if set) for exactly one cycle, then return to IDLE.
  - The requester must drop req in the cycle after it samples done; otherwise a new transaction starts.
- Address arithmetic is modulo 2**MADDR_SZ. After a successful alignment/range check, no wrap can occur within an access.
- Async reset mid-transaction:
  - ram_we drops immediately; all outputs clear.
  - Bytes already strobed stay in the ram (no rollback).
  - No done pulse is issued for the aborted transaction.

Decomposition:
- mem_arb_pkg:
  - size encodings and state encoding.
  - bytes_of(size) function.
  - port-id constants (PORT_IF, PORT_DM).
- Sub-module mem_byte_shifter: 64-bit big-endian serialiser/assembler.
  - Load with wdata and N; emit current byte; shift-in read byte; output the zero-extended result.
  - The FSM and arbiter stay in the top module.

Test Plan:
1. Ram[0x100..0x107] = 01..08; IF read 0x100 → if_rdata = 0x01020304, if_err = 0, if_done in cycle 5, ram_re high in cycles 1-4.
2. DM store size 3, addr 0x200, wdata 0x1122334455667788 → 8 ram_we pulses, ram[0x200..0x207] = 11..88, dm_done in cycle 17. Then DM load size 3 from 0x200 → dm_rdata = 0x1122334455667788.
3. IF 0x100 and DM load size 0 at 0x101 requested in the same cycle → dm_rdata = 0x02 with dm_done in cycle 2; IF granted at the end of cycle 3, if_done in cycle 8, if_rdata = 0x01020304.
4. DM size 2 at 0x102 (misaligned) → dm_done = dm_err = 1 in cycle 1, no ram_we edge. IF at MEM_SZ-4 → OK; IF at MEM_SZ → if_err = 1.
5. 8-byte store at 0x300; assert rst in cycle 6 (after 3 strobes) → ram_we = 0 immediately, busy = 0, no dm_done. Ram[0x300..0x302] updated, 0x303 unchanged. A subsequent IF read is served normally.
6. Back-to-back DM and IF requests both held high → grants alternate DM, IF, DM; neither port starves.
